// File: rtl/bram_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// bram_ctrl_pkg
//   Shared definitions for the BRAM controller family (writer/checker and
//   stream reader).
//
//   Contents:
//     state_e     - controller state encoding (IDLE / RUN / DONE)
//     RD_LAT      - BRAM read latency in cycles (ce0 -> q0 valid)
//     FIFO_DEPTH  - stream FIFO depth; RD_LAT+1 is the minimum that
//                   sustains one word per cycle at full rate
//
//   Configuration macro:
//     BRAM_RD_LAT2_EN - define for BRAMs with an output register
//                       (RD_LAT=2, FIFO_DEPTH=3). When undefined,
//                       RD_LAT=1 and FIFO_DEPTH=2.
// -----------------------------------------------------------------------------
package bram_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

`ifdef BRAM_RD_LAT2_EN
  localparam int RD_LAT = 2;
`else
  localparam int RD_LAT = 1;
`endif

  // One slot per read that can be in the BRAM pipeline plus one for the
  // word currently presented downstream.
  localparam int FIFO_DEPTH = RD_LAT + 1;

endpackage : bram_ctrl_pkg

// File: rtl/bram_rd_fifo.sv
// -----------------------------------------------------------------------------
// bram_rd_fifo
//   Small synchronous FIFO holding stream data returned by the BRAM.
//   Simultaneous push and pop are allowed (occupancy unchanged). The head
//   entry is always visible on head_data (first-word fall-through), so the
//   consumer sees data in the same cycle the FIFO becomes non-empty.
//
//   Parameters:
//     DWIDTH - data width
//     DEPTH  - number of entries (need not be a power of two)
//
//   Ports:
//     clk        in   clock, rising edge
//     reset_n    in   asynchronous active-low reset (clears all entries)
//     push       in   write push_data this cycle
//     push_data  in   DWIDTH data to write
//     pop        in   remove head entry this cycle
//     head_data  out  DWIDTH oldest entry
//     count      out  current occupancy
//     empty      out  occupancy is zero
// -----------------------------------------------------------------------------
module bram_rd_fifo #(
  parameter int DWIDTH = 16,
  parameter int DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [DWIDTH-1:0]          push_data,
  input  logic                       pop,
  output logic [DWIDTH-1:0]          head_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              full;
  logic              do_push;
  logic              do_pop;
  logic [DWIDTH-1:0] entry_vals [DEPTH];

  // Pointer increment with explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return '0;
    end
    return p + PW'(1);
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is only legal when the head leaves this cycle.
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage: one register per entry, written only when the write pointer
  // selects it. Entries reset to zero so the head reads 0 out of reset.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [DWIDTH-1:0] entry_q, entry_d;

    always_comb begin
      entry_d = entry_q;
      if (do_push && (wr_ptr_q == PW'(gi))) begin
        entry_d = push_data;
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        entry_q <= '0;
      end else begin
        entry_q <= entry_d;
      end
    end

    assign entry_vals[gi] = entry_q;
  end

  assign head_data = entry_vals[rd_ptr_q];
  assign count     = count_q;

endmodule : bram_rd_fifo

// File: rtl/bram_stream_reader.sv
// -----------------------------------------------------------------------------
// bram_stream_reader
//   On an i_run pulse, reads i_num_cnt consecutive words (addresses
//   0..i_num_cnt-1) from a single-port BRAM interface and streams them out
//   in address order on a valid/ready interface. Reads are issued only when
//   the FIFO is guaranteed room for the returning data (credit rule), so
//   backpressure never loses or duplicates a word.
//
//   Configuration macro:
//     BRAM_RD_LAT2_EN - 2-cycle BRAM read latency (see bram_ctrl_pkg).
//
//   Parameters:
//     DWIDTH   - BRAM data width
//     AWIDTH   - BRAM address width, also width of i_num_cnt
//     MEM_SIZE - BRAM depth in words
//
//   Ports:
//     clk         in   clock, rising edge
//     reset_n     in   asynchronous active-low reset
//     i_run       in   start pulse, only honoured in IDLE
//     i_num_cnt   in   word count, latched when i_run is accepted
//     o_idle      out  high in IDLE
//     o_read      out  high in RUN
//     o_done      out  one-cycle pulse in DONE
//     addr0       out  BRAM address
//     ce0         out  BRAM read strobe
//     we0         out  BRAM write enable (always 0)
//     d0          out  BRAM write data (always 0)
//     q0          in   BRAM read data, valid RD_LAT cycles after ce0
//     o_valid     out  stream data valid (FIFO non-empty)
//     o_mem_data  out  stream data (FIFO head)
//     i_ready     in   downstream ready
// -----------------------------------------------------------------------------
module bram_stream_reader
  import bram_ctrl_pkg::*;
#(
  parameter int DWIDTH   = 16,
  parameter int AWIDTH   = 7,
  parameter int MEM_SIZE = 128
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_run,
  input  logic [AWIDTH-1:0] i_num_cnt,
  output logic              o_idle,
  output logic              o_read,
  output logic              o_done,
  output logic [AWIDTH-1:0] addr0,
  output logic              ce0,
  output logic              we0,
  output logic [DWIDTH-1:0] d0,
  input  logic [DWIDTH-1:0] q0,
  output logic              o_valid,
  output logic [DWIDTH-1:0] o_mem_data,
  input  logic              i_ready
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  // Occupancy (FIFO + in-flight) can reach FIFO_DEPTH + RD_LAT, so one
  // extra bit over the FIFO count is enough headroom.
  localparam int OW = CW + 1;
  localparam logic [AWIDTH:0] ADDR_LIMIT = (AWIDTH + 1)'(MEM_SIZE);

  state_e              state_q, state_d;
  logic [AWIDTH-1:0]   num_q, num_d;
  logic [AWIDTH-1:0]   issue_q, issue_d;
  logic [RD_LAT-1:0]   inflight_q, inflight_d;

  logic [CW-1:0]       fifo_count;
  logic                fifo_empty;
  logic                fifo_push;
  logic                fifo_pop;
  logic [OW-1:0]       inflight_cnt;
  logic [OW-1:0]       occupancy;
  logic                credit_ok;
  logic                issue_rd;
  logic                drained;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Run is complete once every word has been issued, returned and consumed.
  assign drained = (issue_q == num_q) && (inflight_q == '0) && fifo_empty;

  // ---------------------------------------------------------------------------
  // FSM: next state and state-decoded outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    o_idle  = 1'b0;
    o_read  = 1'b0;
    o_done  = 1'b0;
    case (state_q)
      S_IDLE: begin
        o_idle = 1'b1;
        if (i_run) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        o_read = 1'b1;
        if (drained) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        o_done  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read issue with credit check
  // ---------------------------------------------------------------------------
  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight_cnt = inflight_cnt + OW'(inflight_q[i]);
    end
  end

  // A word popped this cycle frees its slot in time for a read issued now,
  // which is what lets the minimum-depth FIFO sustain one word per cycle.
  assign occupancy = OW'(fifo_count) + inflight_cnt - OW'(fifo_pop);
  assign credit_ok = (occupancy < OW'(FIFO_DEPTH));

  assign issue_rd = (state_q == S_RUN) && (issue_q != num_q) &&
                    ({1'b0, issue_q} < ADDR_LIMIT) && credit_ok;

  assign ce0   = issue_rd;
  assign addr0 = issue_q;
  assign we0   = 1'b0;
  assign d0    = '0;

  // ---------------------------------------------------------------------------
  // Counters and in-flight pipeline
  // ---------------------------------------------------------------------------
  always_comb begin
    num_d   = num_q;
    issue_d = issue_q;
    if ((state_q == S_IDLE) && i_run) begin
      // Count is captured only here; it is never re-sampled mid-run.
      num_d   = i_num_cnt;
      issue_d = '0;
    end else if (state_q == S_DONE) begin
      // Park the address at 0 between runs.
      issue_d = '0;
    end else if (issue_rd) begin
      issue_d = issue_q + AWIDTH'(1);
    end
  end

  // Bit k set means a read issued k+1 cycles ago; the top bit marks the
  // cycle in which q0 carries that read's data.
  assign inflight_d = RD_LAT'({inflight_q, issue_rd});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      num_q      <= '0;
      issue_q    <= '0;
      inflight_q <= '0;
    end else begin
      num_q      <= num_d;
      issue_q    <= issue_d;
      inflight_q <= inflight_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stream FIFO
  // ---------------------------------------------------------------------------
  assign fifo_push = inflight_q[RD_LAT-1];
  assign fifo_pop  = o_valid && i_ready;
  assign o_valid   = !fifo_empty;

  bram_rd_fifo #(
    .DWIDTH (DWIDTH),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .push_data (q0),
    .pop       (fifo_pop),
    .head_data (o_mem_data),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

endmodule : bram_stream_reader

// File: doc/bram_stream_reader.md
Name: bram_stream_reader

Overview:
- Read-side counterpart to the BRAM writer/checker controller.
- On an i_run pulse, reads i_num_cnt consecutive words from a single-port BRAM interface (addr0/ce0/we0/q0/d0), starting at address 0.
- Streams the words out in order on a valid/ready interface, with a small credit-based FIFO to absorb BRAM read latency under backpressure.
- Sits between a true_dpbram port and any downstream consumer.

Parameters:
- DWIDTH, 16, BRAM data width.
- AWIDTH, 7, BRAM address width; also the width of i_num_cnt.
- MEM_SIZE, 128, BRAM depth in words.

Ports:
- clk  input  1  single clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- i_run  input  1  start pulse; sampled only in IDLE.
- i_num_cnt  input  AWIDTH  number of words to read; latched on an accepted i_run.
- o_idle  output  1  high in IDLE.
- o_read  output  1  high in RUN.
- o_done  output  1  one-cycle pulse in DONE.
- addr0  output  AWIDTH  BRAM address.
- ce0  output  1  BRAM chip enable (read strobe).
- we0  output  1  tied to 0.
- d0  output  DWIDTH  tied to 0.
- q0  input  DWIDTH  BRAM read data, valid RD_LAT cycles after ce0.
- o_valid  output  1  stream data valid.
- o_mem_data  output  DWIDTH  stream data (FIFO head).
- i_ready  input  1  downstream ready.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: state=IDLE, o_idle=1, o_read=0, o_done=0, ce0=0, addr0=0, o_valid=0, o_mem_data=0, all counters and the FIFO cleared, in-flight reads discarded.
- FSM: IDLE -> RUN on i_run. RUN -> DONE when issued==num, in-flight==0 and FIFO empty. DONE -> IDLE unconditionally after 1 cycle.
- i_num_cnt=0: IDLE -> RUN -> DONE with no ce0. o_done asserts 2 cycles after the i_run edge.
- i_run outside IDLE is ignored. i_num_cnt is not re-sampled mid-run.
- Read issue:
  - ce0=1 with addr0=issue counter when in RUN, issued<num, and (fifo_cnt + inflight − (o_valid & i_ready)) < FIFO_DEPTH.
  - The issue counter increments on every ce0.
  - Addresses run 0..num−1 with no wrap.
- RD_LAT=1: q0 is captured into the FIFO on the cycle after ce0. inflight is a shift/valid pipeline of RD_LAT bits.
- FIFO:
  - FIFO_DEPTH = RD_LAT+1.
  - Push and pop in the same cycle are allowed; occupancy is unchanged.
  - Never overflows, guaranteed by the credit rule.
- Stream rules:
  - o_valid = FIFO non-empty.
  - While o_valid && !i_ready, o_mem_data and o_valid hold stable.
  - Transfer occurs when o_valid && i_ready.
  - Data leaves strictly in address order, with no loss or duplication.
- Throughput: with i_ready held at 1, one word per cycle after the initial RD_LAT+1 cycle fill. First o_valid appears RD_LAT+1 cycles after entering RUN.
- Reset mid-operation: immediate return to reset values. The next i_run restarts at address 0.

Optional Feature:
- Macro: BRAM_RD_LAT2_EN.
- Defined: RD_LAT=2 for BRAMs with an output register. q0 is captured 2 cycles after ce0. FIFO_DEPTH=3. Full 1 word/cycle throughput is retained.
- Undefined: RD_LAT=1, FIFO_DEPTH=2.

Decomposition:
- Shared package bram_ctrl_pkg holds:
  - State encoding S_IDLE=2'b00, S_RUN=2'b01, S_DONE=2'b10.
  - RD_LAT and FIFO_DEPTH localparams, selected by BRAM_RD_LAT2_EN.
- One natural sub-module: bram_rd_fifo. It is a parameterised small synchronous FIFO with push/pop/count/empty, holding the stream data.

Test Plan:
1. Reset check: assert reset_n=0 then release -> o_idle=1, ce0=0, we0=0, o_valid=0, o_done=0.
2. Continuous stream: preload mem[i]=16'hA000+i via port B, i_num_cnt=100, i_ready=1 -> 100 beats A000..A063 in order, consecutive after the first, one o_done pulse, then o_idle=1.
3. Backpressure: i_num_cnt=100, i_ready pattern 1,0,0,1 repeating -> all 100 words in order with no drop or duplicate; o_mem_data stable while stalled; FIFO never exceeds FIFO_DEPTH; ce0 pauses.
4. Zero count: i_num_cnt=0 -> ce0 never asserts, o_valid never asserts, o_done 2 cycles after i_run.
5. Abuse: i_run pulsed again during RUN is ignored (exactly 100 beats). reset_n pulsed low after beat 40 -> outputs return to reset values; a new run with i_num_cnt=5 yields A000..A004.
6. Maximum count: i_num_cnt=127 -> addr0 sweeps 0..126, 127 beats ending with A07E. Repeat tests 2–3 with BRAM_RD_LAT2_EN defined, against a 2-cycle-latency BRAM model.
